// File: rtl/id_exe_vec_stage_if.sv
// id_exe_vec_stage_if: upstream/downstream handshake and payload bundle for the ID->EXE vector stage
interface id_exe_vec_stage_if #(
  parameter int LANES       = 4,
  parameter int WIDTH       = 16,
  parameter int RD_W        = 4,
  parameter int ALU_W       = 4,
  parameter int STALL_CNT_W = 16
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_vec_a;
  logic [LANES*WIDTH-1:0] in_vec_b;
  logic [WIDTH-1:0]       in_sc_a;
  logic [WIDTH-1:0]       in_sc_b;
  logic [RD_W-1:0]        in_rd;
  logic [ALU_W-1:0]       in_alu_ctrl;
  logic [4:0]             in_ctrl;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_vec_a;
  logic [LANES*WIDTH-1:0] out_vec_b;
  logic [WIDTH-1:0]       out_sc_a;
  logic [WIDTH-1:0]       out_sc_b;
  logic [RD_W-1:0]        out_rd;
  logic [ALU_W-1:0]       out_alu_ctrl;
  logic [4:0]             out_ctrl;
  logic [1:0]             occupancy;
  logic [STALL_CNT_W-1:0] stall_cycles;
  modport master (
    output flush, in_valid, in_vec_a, in_vec_b, in_sc_a, in_sc_b, in_rd, in_alu_ctrl, in_ctrl, out_ready,
    input  in_ready, out_valid, out_vec_a, out_vec_b, out_sc_a, out_sc_b, out_rd, out_alu_ctrl, out_ctrl,
           occupancy, stall_cycles
  );
  modport slave (
    input  flush, in_valid, in_vec_a, in_vec_b, in_sc_a, in_sc_b, in_rd, in_alu_ctrl, in_ctrl, out_ready,
    output in_ready, out_valid, out_vec_a, out_vec_b, out_sc_a, out_sc_b, out_rd, out_alu_ctrl, out_ctrl,
           occupancy, stall_cycles
  );
endinterface

// File: rtl/id_exe_vec_stage.sv
// id_exe_vec_stage: ID->EXE register stage with 2-entry skid buffer, flush and saturating stall counter
module id_exe_vec_stage #(
  parameter int LANES       = 4,
  parameter int WIDTH       = 16,
  parameter int RD_W        = 4,
  parameter int ALU_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  id_exe_vec_stage_if.slave  bus
);
  localparam int P = 2*LANES*WIDTH + 2*WIDTH + RD_W + ALU_W + 5;
  // encoding doubles as the occupancy count
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t                 r_state, w_next;
  logic [P-1:0]           r_main, r_skid, w_in;
  logic [STALL_CNT_W-1:0] r_stall;
  logic [4:0]             w_ctrl;
  logic                   w_acc, w_con, w_ld_main, w_ld_skid;
  assign w_in = {bus.in_vec_a, bus.in_vec_b, bus.in_sc_a, bus.in_sc_b, bus.in_rd, bus.in_alu_ctrl, bus.in_ctrl};
  assign bus.in_ready  = r_state != FULL;
  assign bus.out_valid = r_state != EMPTY;
  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_con = bus.out_valid && bus.out_ready;
  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = EMPTY;
    else case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc && !w_con) ? FULL : (!w_acc && w_con) ? EMPTY : ONE;
      FULL:    w_next = w_con ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
    w_ld_main = !bus.flush && (r_state == FULL ? w_con : w_acc && (r_state == EMPTY || w_con));
    w_ld_skid = !bus.flush && r_state == ONE && w_acc && !w_con;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= EMPTY;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main  <= '0;
      r_skid  <= '0;
      r_stall <= '0;
    end else begin
      if (w_ld_main) r_main <= r_state == FULL ? r_skid : w_in;
      if (w_ld_skid) r_skid <= w_in;
      if (bus.out_valid && !bus.out_ready && !bus.flush && !(&r_stall)) r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end
  assign {bus.out_vec_a, bus.out_vec_b, bus.out_sc_a, bus.out_sc_b, bus.out_rd, bus.out_alu_ctrl, w_ctrl} = r_main;
  assign bus.out_ctrl     = bus.out_valid ? w_ctrl : 5'd0;
  assign bus.occupancy    = r_state;
  assign bus.stall_cycles = r_stall;
endmodule

// File: tb/tb_id_exe_vec_stage.sv
// tb_id_exe_vec_stage: scoreboard bench for the ID->EXE vector stage
module tb_id_exe_vec_stage;
  typedef struct packed {
    logic [63:0] va, vb;
    logic [15:0] sa, sb;
    logic [3:0]  rd, alu;
    logic [4:0]  ctrl;
  } pl_t;

  logic clk, reset;
  int   checks, errors;
  pl_t  q[$];

  id_exe_vec_stage_if bus ();
  id_exe_vec_stage_if #(.STALL_CNT_W(3)) bus2 ();
  id_exe_vec_stage dut (.clk(clk), .reset(reset), .bus(bus));
  id_exe_vec_stage #(.STALL_CNT_W(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pl_t mk(input logic [15:0] s);
    pl_t p;
    p.va   = {s + 16'd3, s + 16'd2, s + 16'd1, s};
    p.vb   = ~p.va;
    p.sa   = s;
    p.sb   = ~s;
    p.rd   = s[3:0];
    p.alu  = s[7:4];
    p.ctrl = s[4:0] ^ 5'b10101;
    return p;
  endfunction

  function automatic pl_t outp();
    return {bus.out_vec_a, bus.out_vec_b, bus.out_sc_a, bus.out_sc_b, bus.out_rd, bus.out_alu_ctrl, bus.out_ctrl};
  endfunction

  task automatic drive(input pl_t p);
    {bus.in_vec_a, bus.in_vec_b, bus.in_sc_a, bus.in_sc_b, bus.in_rd, bus.in_alu_ctrl, bus.in_ctrl} = p;
  endtask

  task automatic send(input pl_t p);
    bit acc;
    int n;
    drive(p);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready && !bus.flush && !reset;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) q.push_back(p);
    else chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  pl_t prev, cur, expv;
  bit  prev_hold;
  always @(negedge clk) begin
    if (reset) prev_hold = 1'b0;
    else begin
      cur = outp();
      if (prev_hold && bus.out_valid) begin
        checks++;
        if (cur !== prev) begin
          errors++;
          $display("FAIL hold_stable: got %h expected %h", cur, prev);
        end
      end
      if (!bus.out_valid) chk("ctrl_gated", 64'(bus.out_ctrl), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got sc_a %h expected no entry", cur.sa);
        end else begin
          expv = q.pop_front();
          if (cur !== expv) begin
            errors++;
            $display("FAIL out_entry: got %h expected %h", cur, expv);
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pl_t e1;
    checks = 0;
    errors = 0;
    e1.va = {16'h1111, 16'hEEEE, 16'hCCCC, 16'hAAAA};
    e1.vb = 64'h0123_4567_89AB_CDEF;
    e1.sa = 16'h3333;
    e1.sb = 16'h4444;
    e1.rd = 4'hA;
    e1.alu = 4'hC;
    e1.ctrl = 5'b11011;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(e1);
    bus.in_valid = 1'b1;
    bus2.flush = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    {bus2.in_vec_a, bus2.in_vec_b, bus2.in_sc_a, bus2.in_sc_b, bus2.in_rd, bus2.in_alu_ctrl, bus2.in_ctrl} = mk(16'h0042);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_stall", 64'(bus.stall_cycles), 64'd0);
    bus.out_ready = 1'b1;
    reset = 1'b0;
    send(e1);
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    chk("first_sc_a", 64'(bus.out_sc_a), 64'h3333);
    chk("first_ctrl", 64'(bus.out_ctrl), 64'b11011);
    chk("first_lane0", 64'(bus.out_vec_a[15:0]), 64'hAAAA);
    chk("first_lane3", 64'(bus.out_vec_a[63:48]), 64'h1111);

    for (int i = 1; i <= 8; i++) begin
      send(mk(16'(i)));
      chk("stream_occ", 64'(bus.occupancy), 64'd1);
      chk("stream_sc_a", 64'(bus.out_sc_a), 64'(i));
    end
    bus.in_valid = 1'b0;
    drain();
    chk("stream_stall", 64'(bus.stall_cycles), 64'd0);

    bus.out_ready = 1'b0;
    fork
      begin
        send(mk(16'h0B01));
        send(mk(16'h0B02));
        send(mk(16'h0B03));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_occ", 64'(bus.occupancy), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_first", 64'(bus.out_sc_a), 64'h0B01);
        chk("bp_stall", 64'(bus.stall_cycles), 64'd3);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_final", 64'(bus.stall_cycles), 64'd3);

    bus.out_ready = 1'b0;
    send(mk(16'h0F01));
    send(mk(16'h0F02));
    chk("fl_full", 64'(bus.occupancy), 64'd2);
    drive(mk(16'h5555));
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_occ", 64'(bus.occupancy), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_stall_kept", 64'(bus.stall_cycles), 64'd4);
    bus.out_ready = 1'b1;
    send(mk(16'h0A11));
    bus.in_valid = 1'b0;
    drain();

    bus2.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_count3", 64'(bus2.stall_cycles), 64'd3);
    repeat (9) @(posedge clk);
    #1;
    chk("sat_cap", 64'(bus2.stall_cycles), 64'd7);

    bus.out_ready = 1'b0;
    send(mk(16'h0C01));
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall_cycles), 64'd0);
    chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_stall2", 64'(bus2.stall_cycles), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(mk(16'h0D01));
    chk("post_rst_sc_a", 64'(bus.out_sc_a), 64'h0D01);
    bus.in_valid = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
